// File: rtl/threshold_pkg.sv
// Shared encodings for the threshold engine: output modes, controller states and
// the supported read-latency range.
package threshold_pkg;

  typedef enum logic [1:0] {
    MODE_BINARY     = 2'd0,
    MODE_BINARY_INV = 2'd1,
    MODE_TRUNC      = 2'd2,
    MODE_TOZERO     = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  // Out-of-range latencies are pinned to the nearest supported depth.
  function automatic int bound_latency(input int lat);
    if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
    if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/threshold_pixel_op.sv
// Per-pixel datapath: offset threshold with clamping, strict compare, mode select,
// and the registered result / write-enable stage.
module threshold_pixel_op
  import threshold_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        valid,
  input  mode_t                       mode,
  input  logic signed [DATA_BITS:0]   offset,
  input  logic        [DATA_BITS-1:0] pixel,
  input  logic        [DATA_BITS-1:0] threshold,
  output logic        [DATA_BITS-1:0] result,
  output logic                        wren
);

  localparam logic [DATA_BITS-1:0] MAXVAL = '1;

  logic signed [DATA_BITS+1:0] t_wide;
  logic        [DATA_BITS-1:0] t_eff;
  logic        [DATA_BITS-1:0] result_next;
  logic                        hit;

  // Two extra bits keep threshold - offset exact over the full signed offset range.
  always_comb begin
    t_wide = $signed({2'b00, threshold}) - $signed({offset[DATA_BITS], offset});
    if (t_wide[DATA_BITS+1]) begin
      t_eff = '0;
    end else if (t_wide[DATA_BITS]) begin
      t_eff = MAXVAL;
    end else begin
      t_eff = t_wide[DATA_BITS-1:0];
    end
    hit = (pixel > t_eff);
  end

  always_comb begin
    result_next = '0;
    case (mode)
      MODE_BINARY:     result_next = hit ? MAXVAL : '0;
      MODE_BINARY_INV: result_next = hit ? '0 : MAXVAL;
      MODE_TRUNC:      result_next = hit ? t_eff : pixel;
      MODE_TOZERO:     result_next = hit ? pixel : '0;
      default:         result_next = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result <= '0;
      wren   <= 1'b0;
    end else begin
      wren <= valid;
      if (valid) begin
        result <= result_next;
      end
    end
  end

endmodule

// File: rtl/threshold_engine.sv
// Raster-scan threshold engine: walks every pixel once per pass, reads image and local
// threshold at the same address, and writes the thresholded result back in order.
module threshold_engine
  import threshold_pkg::*;
#(
  parameter int WIDTH_BITS   = 7,
  parameter int HEIGHT_BITS  = 7,
  parameter int DATA_BITS    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        iStart,
  input  logic        [1:0]           iMode,
  input  logic signed [DATA_BITS:0]   iOffset,
  output logic        [WIDTH_BITS-1:0]  oImageCol,
  output logic        [HEIGHT_BITS-1:0] oImageRow,
  input  logic        [DATA_BITS-1:0] iImageData,
  output logic        [WIDTH_BITS-1:0]  oThresholdCol,
  output logic        [HEIGHT_BITS-1:0] oThresholdRow,
  input  logic        [DATA_BITS-1:0] iThresholdData,
  output logic        [WIDTH_BITS-1:0]  oResultCol,
  output logic        [HEIGHT_BITS-1:0] oResultRow,
  output logic        [DATA_BITS-1:0] oResultData,
  output logic                        oResultWren,
  output logic                        oBusy,
  output logic                        finished
);

  localparam int POS_BITS = WIDTH_BITS + HEIGHT_BITS;
  localparam int LAT      = bound_latency(READ_LATENCY);
  localparam logic [POS_BITS-1:0] LAST_POS = '1;

  state_t                     state_reg;
  logic [POS_BITS-1:0]        pos_reg;
  mode_t                      mode_reg;
  logic signed [DATA_BITS:0]  offset_reg;
  logic                       busy_reg;
  logic                       finished_reg;

  logic [LAT-1:0]             pipe_valid;
  logic [POS_BITS-1:0]        pipe_addr [LAT];
  logic [POS_BITS-1:0]        result_addr_reg;

  logic                       issue;
  logic                       pipe_pending;
  logic                       wren_int;

  assign issue        = (state_reg == ST_RUN);
  assign pipe_pending = |pipe_valid;

  // The final write is the one that leaves nothing behind it in the delay line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      pos_reg      <= '0;
      mode_reg     <= MODE_BINARY;
      offset_reg   <= '0;
      busy_reg     <= 1'b0;
      finished_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (iStart) begin
            state_reg    <= ST_RUN;
            pos_reg      <= '0;
            mode_reg     <= mode_t'(iMode);
            offset_reg   <= iOffset;
            busy_reg     <= 1'b1;
            finished_reg <= 1'b0;
          end
        end
        ST_RUN: begin
          if (pos_reg == LAST_POS) begin
            state_reg <= ST_DRAIN;
          end else begin
            pos_reg <= pos_reg + POS_BITS'(1);
          end
        end
        ST_DRAIN: begin
          if (wren_int && !pipe_pending) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            finished_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Address delay line; its last stage lines up with the returning read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_valid      <= '0;
      result_addr_reg <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= issue;
      pipe_addr[0]  <= pos_reg;
      for (int i = 1; i < LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
      end
      if (pipe_valid[LAT-1]) begin
        result_addr_reg <= pipe_addr[LAT-1];
      end
    end
  end

  threshold_pixel_op #(
    .DATA_BITS(DATA_BITS)
  ) u_pixel_op (
    .clock     (clock),
    .reset     (reset),
    .valid     (pipe_valid[LAT-1]),
    .mode      (mode_reg),
    .offset    (offset_reg),
    .pixel     (iImageData),
    .threshold (iThresholdData),
    .result    (oResultData),
    .wren      (wren_int)
  );

  assign oImageCol     = pos_reg[WIDTH_BITS-1:0];
  assign oImageRow     = pos_reg[POS_BITS-1:WIDTH_BITS];
  assign oThresholdCol = pos_reg[WIDTH_BITS-1:0];
  assign oThresholdRow = pos_reg[POS_BITS-1:WIDTH_BITS];
  assign oResultCol    = result_addr_reg[WIDTH_BITS-1:0];
  assign oResultRow    = result_addr_reg[POS_BITS-1:WIDTH_BITS];
  assign oResultWren   = wren_int;
  assign oBusy         = busy_reg;
  assign finished      = finished_reg;

endmodule
